nsnrflag_bank: RTL
==================

# nsnrflag_bank

Clocked, parametrised bank of active-low set/reset flags for the standard-cell library's digital test and control blocks. Each of WIDTH channels synchronises its own asynchronous active-low set and clear inputs and resolves them through a selectable priority mode, optionally triggering on falling edges instead of levels. Flags are held in flip-flops with complementary outputs. A four-phase masked clear handshake lets a controller clear selected flags.

## Interface
- WIDTH, 4: number of flag channels (1..32).
- SYNC, 2: synchroniser flip-flop stages on each nset/nclr bit (0..3; 0 = inputs used directly, already synchronous).
- MODE, 0: conflict resolution when set and clear are both active: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
- EDGE, 0: 0 level-sensitive, 1 falling-edge-triggered on the synchronised nset/nclr.

- ck  input  1  clock; all state changes on rising edge.
- nrst  input  1  asynchronous active-low reset.
- nset  input  WIDTH  per-channel active-low set request.
- nclr  input  WIDTH  per-channel active-low clear request.
- clr_req  input  1  masked clear request, four-phase.
- clr_mask  input  WIDTH  channels cleared by the handshake; sampled with clr_req.
- clr_ack  output  1  clear handshake acknowledge.
- q  output  WIDTH  flag state.
- nq  output  WIDTH  strict complement of q.
- any  output  1  registered OR of q.

## Operation
- Reset (nrst low, asynchronous): all synchroniser stages and edge-history registers = 1 (inactive), q = 0, nq = all ones, any = 0, clr_ack = 0. Release is synchronous to the next rising ck.
- Synchroniser: s_set[i] / s_clr[i] = nset[i] / nclr[i] delayed SYNC flops.
- Set condition per channel: level mode, set = ~s_set; edge mode, set = h_set & ~s_set, where h_set is s_set registered one cycle. The same rule applies to the clear condition.
- Software clear: swc[i] = clr_mask[i] for the one cycle in which a handshake is accepted. swc[i] is ORed into the clear condition.
- Next q[i] is determined by the conditions and MODE:
  - Neither condition active: hold.
  - Set only: 1.
  - Clear only: 0.
  - Both active: MODE 0 gives 0, MODE 1 gives 1, MODE 2 holds, MODE 3 gives ~q[i].
- nq = ~q at all times; q and nq are never both 1.
- any is registered from next-q, so it changes on the same edge as q.
- Clear handshake states:
  - IDLE (clr_ack = 0): on an edge sampling clr_req = 1, apply swc from clr_mask at that edge, go to ACK with clr_ack = 1.
  - ACK: hold clr_ack = 1 while clr_req = 1; no further clears. On an edge sampling clr_req = 0, go to IDLE with clr_ack = 0.
  - Exactly one clear is performed per handshake, however long clr_req stays high.
  - clr_mask is ignored except at the accepting edge.
- Out-of-range parameter values are illegal; implementation asserts at elaboration.

## Timing
- Input-to-q latency: SYNC+1 rising edges from the first edge sampling the input low (SYNC = 0 gives 1 edge). Edge mode adds no latency.
- Edge mode: an input held low produces a single event. Re-triggering requires the synchronised input to go high for at least one cycle.
- Level mode: an input held low keeps re-asserting its condition every cycle. In MODE 3 with both inputs held low, q toggles every cycle.
- clr_req to clr_ack: 1 edge. The q update from a software clear occurs on the same edge clr_ack rises.
- A software clear coinciding with a set condition on the same channel is resolved by MODE, exactly as for nclr.
- nrst asserted mid-handshake: clr_ack drops asynchronously to 0. After release, a clr_req still held high is a new request and is accepted on the first edge.
- Inputs must be stable for one ck period only when SYNC = 0; otherwise they are fully asynchronous.

## Test plan
- Reset: with nrst low, toggle all inputs -> q = 0, nq = all ones, any = 0, clr_ack = 0 throughout; first q change occurs only after release.
- Latency (WIDTH=4, SYNC=2, EDGE=0, MODE=0): pull nset[2] low at edge 10 -> q = 4'b0100 and any = 1 after edge 12, not earlier; pull nclr[2] low -> q = 0 two edges after sampling.
- Conflict modes: nset[0] and nclr[0] low together, q[0] initially 1:
  - MODE 0 -> q[0] = 0.
  - MODE 1 -> q[0] = 1.
  - MODE 2 -> q[0] stays 1.
  - MODE 3 -> q[0] alternates 0, 1, 0 on successive edges.
- Edge mode (EDGE=1): hold nset[1] low 20 cycles after clearing -> q[1] sets once. Clear via nclr pulse -> q[1] stays 0 while nset[1] remains low. Release and re-pull nset[1] -> q[1] sets again.
- Handshake: q = 4'b1111, clr_mask = 4'b0101, clr_req high for 5 cycles -> q = 4'b1010 on the acknowledging edge, clr_ack high until one edge after clr_req falls, no second clear. Set and masked clear on the same channel in MODE 1 -> q stays 1.
- Reset mid-handshake: assert nrst while clr_ack = 1 and clr_req stays high -> clr_ack = 0 immediately. After release, a fresh clear is performed on the first edge and clr_ack = 1.

Source files
------------

// File: rtl/nsnrflag_bank.sv
// Bank of active-low set/clear flags with per-channel synchronisers, selectable
// conflict resolution, optional falling-edge triggering and a masked clear handshake.
module nsnrflag_bank #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SYNC  = 2,
  parameter int unsigned MODE  = 0,
  parameter int unsigned EDGE  = 0
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic [WIDTH-1:0] nset,
  input  logic [WIDTH-1:0] nclr,
  input  logic             clr_req,
  input  logic [WIDTH-1:0] clr_mask,
  output logic             clr_ack,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             any
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("nsnrflag_bank: WIDTH must be 1..32");
  end
  if (SYNC > 3) begin : g_bad_sync
    $error("nsnrflag_bank: SYNC must be 0..3");
  end
  if (MODE > 3) begin : g_bad_mode
    $error("nsnrflag_bank: MODE must be 0..3");
  end
  if (EDGE > 1) begin : g_bad_edge
    $error("nsnrflag_bank: EDGE must be 0 or 1");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} hs_state_e;

  logic [WIDTH-1:0] s_set, s_clr;
  logic [WIDTH-1:0] h_set_q, h_clr_q;
  logic [WIDTH-1:0] set_c, clr_c, swc_c;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic             any_q;
  hs_state_e        state_q, state_d;
  logic             accept_c;

  // Synchroniser chains; reset to the inactive (high) level.
  if (SYNC == 0) begin : g_nosync
    assign s_set = nset;
    assign s_clr = nclr;
  end else begin : g_sync
    logic [WIDTH-1:0] set_q [SYNC];
    logic [WIDTH-1:0] clr_q [SYNC];

    always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
        for (int i = 0; i < int'(SYNC); i++) begin
          set_q[i] <= '1;
          clr_q[i] <= '1;
        end
      end else begin
        set_q[0] <= nset;
        clr_q[0] <= nclr;
        for (int i = 1; i < int'(SYNC); i++) begin
          set_q[i] <= set_q[i-1];
          clr_q[i] <= clr_q[i-1];
        end
      end
    end

    assign s_set = set_q[SYNC-1];
    assign s_clr = clr_q[SYNC-1];
  end

  // One-cycle history of the synchronised inputs for falling-edge detection.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      h_set_q <= '1;
      h_clr_q <= '1;
    end else begin
      h_set_q <= s_set;
      h_clr_q <= s_clr;
    end
  end

  // Handshake state register.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (clr_req)  state_d = ST_ACK;
      ST_ACK:  if (!clr_req) state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs: the clear is applied only on the accepting edge.
  always_comb begin
    accept_c = 1'b0;
    if (state_q == ST_IDLE && clr_req) accept_c = 1'b1;
  end

  assign swc_c = accept_c ? clr_mask : '0;
  assign set_c = (EDGE == 1) ? (h_set_q & ~s_set) : ~s_set;
  assign clr_c = ((EDGE == 1) ? (h_clr_q & ~s_clr) : ~s_clr) | swc_c;

  // Per-channel resolution of set/clear conditions.
  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({set_c[i], clr_c[i]})
        2'b10: flag_d[i] = 1'b1;
        2'b01: flag_d[i] = 1'b0;
        2'b11: begin
          case (MODE)
            0:       flag_d[i] = 1'b0;
            1:       flag_d[i] = 1'b1;
            2:       flag_d[i] = flag_q[i];
            default: flag_d[i] = ~flag_q[i];
          endcase
        end
        default: flag_d[i] = flag_q[i];
      endcase
    end
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      flag_q <= '0;
      any_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      any_q  <= |flag_d;
    end
  end

  assign q       = flag_q;
  assign nq      = ~flag_q;
  assign any     = any_q;
  assign clr_ack = (state_q == ST_ACK);

endmodule
